// File: rtl/cgra_cmem_loader.sv
// cgra_cmem_loader: streams a kernel image from system memory into CGRA context memory
module cgra_cmem_loader #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [31:0]          src_addr_i,
  input  logic [31:0]          dst_addr_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 rd_req_o,
  output logic [31:0]          rd_addr_o,
  input  logic                 rd_gnt_i,
  input  logic                 rd_rvalid_i,
  input  logic [31:0]          rd_rdata_i,
  output logic                 cm_req_o,
  output logic [31:0]          cm_addr_o,
  output logic                 cm_we_o,
  output logic [3:0]           cm_be_o,
  output logic [31:0]          cm_wdata_o,
  input  logic                 cm_gnt_i,
  input  logic                 cm_rvalid_i
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state, state_n;
  logic [31:0] rd_addr, wr_addr;
  logic [LEN_WIDTH-1:0] len, rd_issued, wr_issued, wr_issued_n;
  logic [CW-1:0] rd_out, wr_out, wr_out_n, count;
  logic [AW-1:0] wptr, rptr;
  logic [31:0] mem [FIFO_DEPTH];
  logic run, rd_fire, push, pop, wr_ack, launch;
  assign run = state == RUN;
  // Buffered plus in-flight reads never exceed the FIFO, so a push always has room
  assign rd_req_o = run && rd_issued < len && (count + rd_out) < CW'(FIFO_DEPTH);
  assign rd_addr_o = rd_addr;
  assign cm_req_o = run && count != '0;
  assign cm_addr_o = wr_addr;
  assign cm_we_o = cm_req_o;
  assign cm_be_o = {4{cm_req_o}};
  assign cm_wdata_o = cm_req_o ? mem[rptr] : '0;
  assign busy_o = run || state == FLUSH;
  assign done_o = state == DONE;
  assign rd_fire = rd_req_o && rd_gnt_i;
  assign push = run && rd_rvalid_i;
  assign pop = cm_req_o && cm_gnt_i;
  assign wr_ack = busy_o && cm_rvalid_i;
  assign launch = state == IDLE && start_i && len_i != '0;
  assign wr_issued_n = wr_issued + LEN_WIDTH'(pop);
  assign wr_out_n = wr_out + CW'(pop) - CW'(wr_ack);
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (start_i ? (len_i != '0 ? RUN : DONE) : IDLE)
            : run ? (wr_issued_n == len ? FLUSH : RUN)
            : state == FLUSH ? (wr_out_n == '0 ? DONE : FLUSH)
            : IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      rd_addr <= '0;
      wr_addr <= '0;
      len <= '0;
      rd_issued <= '0;
      wr_issued <= '0;
      rd_out <= '0;
      wr_out <= '0;
      count <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      state <= state_n;
      if (launch) begin
        rd_addr <= src_addr_i;
        wr_addr <= dst_addr_i;
        len <= len_i;
        rd_issued <= '0;
        wr_issued <= '0;
        rd_out <= '0;
        wr_out <= '0;
        count <= '0;
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (rd_fire) begin
          rd_addr <= rd_addr + 32'd4;
          rd_issued <= rd_issued + LEN_WIDTH'(1);
        end
        if (push) wptr <= wptr + AW'(1);
        if (pop) begin
          rptr <= rptr + AW'(1);
          wr_addr <= wr_addr + 32'd4;
        end
        rd_out <= rd_out + CW'(rd_fire) - CW'(push);
        count <= count + CW'(push) - CW'(pop);
        wr_issued <= wr_issued_n;
        wr_out <= wr_out_n;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= rd_rdata_i;
  end
endmodule

// File: tb/tb_cgra_cmem_loader.sv
// tb_cgra_cmem_loader: directed checks of the context-memory loader against hand-computed results
module tb_cgra_cmem_loader;
  logic clk_i = 0, rst_ni = 0, start_i = 0;
  logic [31:0] src_addr_i = 0, dst_addr_i = 0;
  logic [15:0] len_i = 0;
  logic busy_o, done_o, rd_req_o, cm_req_o, cm_we_o;
  logic [31:0] rd_addr_o, cm_addr_o, cm_wdata_o;
  logic [3:0] cm_be_o;
  logic rd_gnt_i = 0, rd_rvalid_i = 0, cm_gnt_i = 0, cm_rvalid_i = 0;
  logic [31:0] rd_rdata_i = 0;

  cgra_cmem_loader dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o),
    .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o), .rd_gnt_i(rd_gnt_i),
    .rd_rvalid_i(rd_rvalid_i), .rd_rdata_i(rd_rdata_i),
    .cm_req_o(cm_req_o), .cm_addr_o(cm_addr_o), .cm_we_o(cm_we_o), .cm_be_o(cm_be_o),
    .cm_wdata_o(cm_wdata_o), .cm_gnt_i(cm_gnt_i), .cm_rvalid_i(cm_rvalid_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {logic [31:0] d; int due;} rd_t;
  typedef struct {logic [31:0] a; logic [31:0] d; int c;} wr_t;
  rd_t rq[$];
  int cq[$];
  wr_t wlog[$];
  logic [31:0] rlog[$];
  int nvec = 0, nerr = 0, cyc = 0, t0 = 0;
  bit rd_rand = 0, cm_gnt_en = 1;
  int rd_delay = 1;
  int done_cnt, done_cyc, busy_cnt, rdreq_cnt, cmreq_cnt, first_rd, first_busy, out_cnt = 0, max_out;

  // Bus slaves: read data equals the read address, responses return in order
  initial forever begin
    @(posedge clk_i);
    cyc++;
    #1;
    rd_rvalid_i = 0;
    cm_rvalid_i = 0;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      rd_rvalid_i = 1;
      rd_rdata_i = rq[0].d;
      rq.delete(0);
      out_cnt--;
    end
    if (cq.size() > 0 && cq[0] <= cyc) begin
      cm_rvalid_i = 1;
      cq.delete(0);
    end
    rd_gnt_i = rd_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    cm_gnt_i = cm_gnt_en;
    @(negedge clk_i);
    if (rd_req_o && rd_gnt_i) begin
      rq.push_back('{rd_addr_o, cyc + (rd_rand ? int'($urandom_range(1, 5)) : rd_delay)});
      rlog.push_back(rd_addr_o);
      out_cnt++;
      if (out_cnt > max_out) max_out = out_cnt;
    end
    if (cm_req_o && cm_gnt_i) begin
      wlog.push_back('{cm_addr_o, cm_wdata_o, cyc});
      cq.push_back(cyc + 1);
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy_o) busy_cnt++;
    if (busy_o && first_busy < 0) first_busy = cyc;
    if (rd_req_o) rdreq_cnt++;
    if (rd_req_o && first_rd < 0) first_rd = cyc;
    if (cm_req_o) cmreq_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  task automatic clear_logs();
    wlog.delete();
    rlog.delete();
    done_cnt = 0;
    busy_cnt = 0;
    rdreq_cnt = 0;
    cmreq_cnt = 0;
    first_rd = -1;
    first_busy = -1;
    max_out = 0;
  endtask

  task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    src_addr_i = s;
    dst_addr_i = d;
    len_i = n;
    start_i = 1;
    t0 = cyc;
    idle(1);
    start_i = 0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (done_o) begin
        ok = 1;
        break;
      end
    end
    idle(1);
  endtask

  task automatic test_reset();
    rst_ni = 0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    nvec++;
    if ({busy_o, done_o, rd_req_o, cm_req_o, cm_we_o} !== 5'b0) begin
      nerr++;
      $display("FAIL reset_ctrl: got %b expected 00000", {busy_o, done_o, rd_req_o, cm_req_o, cm_we_o});
    end
    nvec++;
    if (cm_be_o !== 4'h0) begin
      nerr++;
      $display("FAIL reset_be: got %h expected 0", cm_be_o);
    end
    nvec++;
    if ({rd_addr_o, cm_addr_o, cm_wdata_o} !== 96'b0) begin
      nerr++;
      $display("FAIL reset_data: got %h %h %h expected zeros", rd_addr_o, cm_addr_o, cm_wdata_o);
    end
    idle(1);
    rst_ni = 1;
    idle(2);
    nvec++;
    if ({busy_o, rd_req_o, cm_req_o} !== 3'b0) begin
      nerr++;
      $display("FAIL idle_quiet: got %b expected 000", {busy_o, rd_req_o, cm_req_o});
    end
  endtask

  task automatic test_zero_len();
    bit ok;
    clear_logs();
    start_xfer(32'h1000, 32'h2000, 16'd0);
    wait_done(10, ok);
    idle(3);
    nvec++;
    if (!ok || done_cyc - t0 != 1) begin
      nerr++;
      $display("FAIL zero_done_cycle: got ok=%0d cycle %0d expected cycle 1", ok, done_cyc - t0);
    end
    nvec++;
    if (done_cnt != 1) begin
      nerr++;
      $display("FAIL zero_done_count: got %0d expected 1", done_cnt);
    end
    nvec++;
    if (busy_cnt + rdreq_cnt + cmreq_cnt != 0) begin
      nerr++;
      $display("FAIL zero_activity: got busy=%0d rd=%0d cm=%0d expected 0", busy_cnt, rdreq_cnt, cmreq_cnt);
    end
  endtask

  task automatic test_basic_copy();
    bit ok;
    rd_rand = 0;
    rd_delay = 1;
    cm_gnt_en = 1;
    clear_logs();
    start_xfer(32'h1000, 32'h2000, 16'd8);
    wait_done(100, ok);
    idle(3);
    nvec++;
    if (!ok || first_busy - t0 != 1 || first_rd - t0 != 1) begin
      nerr++;
      $display("FAIL basic_start: got ok=%0d busy@%0d rd@%0d expected busy@1 rd@1", ok, first_busy - t0, first_rd - t0);
    end
    nvec++;
    if (wlog.size() != 8) begin
      nerr++;
      $display("FAIL basic_count: got %0d writes expected 8", wlog.size());
    end
    for (int i = 0; i < wlog.size() && i < 8; i++) begin
      nvec++;
      if ({wlog[i].a, wlog[i].d} !== {32'h2000 + 32'(4 * i), 32'h1000 + 32'(4 * i)}) begin
        nerr++;
        $display("FAIL basic_write[%0d]: got %h/%h expected %h/%h", i, wlog[i].a, wlog[i].d,
                 32'h2000 + 32'(4 * i), 32'h1000 + 32'(4 * i));
      end
    end
    if (wlog.size() == 8) begin
      nvec++;
      if (wlog[0].c - t0 != 3 || wlog[7].c - wlog[0].c != 7) begin
        nerr++;
        $display("FAIL basic_rate: got first@%0d span %0d expected first@3 span 7", wlog[0].c - t0, wlog[7].c - wlog[0].c);
      end
    end
    nvec++;
    if (done_cnt != 1 || done_cyc - t0 != 12) begin
      nerr++;
      $display("FAIL basic_done: got %0d pulses @%0d expected 1 @12", done_cnt, done_cyc - t0);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_logs();
    cm_gnt_en = 0;
    start_xfer(32'h3000, 32'h4000, 16'd16);
    repeat (20) begin
      @(negedge clk_i);
      if (cm_req_o) begin
        nvec++;
        if ({cm_addr_o, cm_wdata_o, cm_we_o, cm_be_o} !== {32'h4000, 32'h3000, 1'b1, 4'hF}) begin
          nerr++;
          $display("FAIL bp_stable: got %h/%h we=%b be=%h expected 00004000/00003000 we=1 be=f",
                   cm_addr_o, cm_wdata_o, cm_we_o, cm_be_o);
        end
      end
    end
    nvec++;
    if (rlog.size() != 4 || rd_req_o !== 1'b0 || cm_req_o !== 1'b1) begin
      nerr++;
      $display("FAIL bp_stall: got reads=%0d rd_req=%b cm_req=%b expected 4 0 1", rlog.size(), rd_req_o, cm_req_o);
    end
    idle(1);
    cm_gnt_en = 1;
    wait_done(200, ok);
    idle(2);
    nvec++;
    if (!ok || wlog.size() != 16 || done_cnt != 1) begin
      nerr++;
      $display("FAIL bp_finish: got ok=%0d writes=%0d done=%0d expected 1 16 1", ok, wlog.size(), done_cnt);
    end
    for (int i = 0; i < wlog.size() && i < 16; i++) begin
      nvec++;
      if ({wlog[i].a, wlog[i].d} !== {32'h4000 + 32'(4 * i), 32'h3000 + 32'(4 * i)}) begin
        nerr++;
        $display("FAIL bp_write[%0d]: got %h/%h expected %h/%h", i, wlog[i].a, wlog[i].d,
                 32'h4000 + 32'(4 * i), 32'h3000 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_random_latency();
    bit ok;
    clear_logs();
    rd_rand = 1;
    start_xfer(32'h8000, 32'h9000, 16'd33);
    wait_done(2000, ok);
    rd_rand = 0;
    idle(2);
    nvec++;
    if (!ok || wlog.size() != 33 || done_cnt != 1) begin
      nerr++;
      $display("FAIL rand_finish: got ok=%0d writes=%0d done=%0d expected 1 33 1", ok, wlog.size(), done_cnt);
    end
    for (int i = 0; i < wlog.size() && i < 33; i++) begin
      nvec++;
      if ({wlog[i].a, wlog[i].d} !== {32'h9000 + 32'(4 * i), 32'h8000 + 32'(4 * i)}) begin
        nerr++;
        $display("FAIL rand_write[%0d]: got %h/%h expected %h/%h", i, wlog[i].a, wlog[i].d,
                 32'h9000 + 32'(4 * i), 32'h8000 + 32'(4 * i));
      end
    end
    nvec++;
    if (max_out > 4) begin
      nerr++;
      $display("FAIL rand_outstanding: got %0d expected at most 4", max_out);
    end
  endtask

  task automatic test_addr_wrap();
    bit ok;
    logic [31:0] exp_r [4];
    exp_r = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h0, 32'h4};
    clear_logs();
    start_xfer(32'hFFFFFFF8, 32'hA000, 16'd4);
    idle(1);
    src_addr_i = 32'h5555_0000;
    len_i = 16'd7;
    start_i = 1;
    idle(2);
    start_i = 0;
    wait_done(100, ok);
    idle(10);
    nvec++;
    if (!ok || rlog.size() != 4 || wlog.size() != 4 || done_cnt != 1) begin
      nerr++;
      $display("FAIL wrap_count: got ok=%0d reads=%0d writes=%0d done=%0d expected 1 4 4 1",
               ok, rlog.size(), wlog.size(), done_cnt);
    end
    for (int i = 0; i < rlog.size() && i < 4; i++) begin
      nvec++;
      if (rlog[i] !== exp_r[i]) begin
        nerr++;
        $display("FAIL wrap_read[%0d]: got %h expected %h", i, rlog[i], exp_r[i]);
      end
    end
    for (int i = 0; i < wlog.size() && i < 4; i++) begin
      nvec++;
      if ({wlog[i].a, wlog[i].d} !== {32'hA000 + 32'(4 * i), exp_r[i]}) begin
        nerr++;
        $display("FAIL wrap_write[%0d]: got %h/%h expected %h/%h", i, wlog[i].a, wlog[i].d,
                 32'hA000 + 32'(4 * i), exp_r[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_logs();
    rd_delay = 5;
    cm_gnt_en = 0;
    start_xfer(32'hB000, 32'hC000, 16'd8);
    idle(2);
    rst_ni = 0;
    idle(1);
    rst_ni = 1;
    @(negedge clk_i);
    nvec++;
    if ({busy_o, done_o, rd_req_o, cm_req_o, cm_we_o, cm_be_o} !== 9'b0) begin
      nerr++;
      $display("FAIL midrst_ctrl: got %b expected 0", {busy_o, done_o, rd_req_o, cm_req_o, cm_we_o, cm_be_o});
    end
    nvec++;
    if ({rd_addr_o, cm_addr_o, cm_wdata_o} !== 96'b0) begin
      nerr++;
      $display("FAIL midrst_data: got %h %h %h expected zeros", rd_addr_o, cm_addr_o, cm_wdata_o);
    end
    idle(1);
    clear_logs();
    idle(12);
    nvec++;
    if (cmreq_cnt + busy_cnt + rdreq_cnt != 0) begin
      nerr++;
      $display("FAIL midrst_stale: got cm=%0d busy=%0d rd=%0d expected 0", cmreq_cnt, busy_cnt, rdreq_cnt);
    end
    rd_delay = 1;
    cm_gnt_en = 1;
    clear_logs();
    start_xfer(32'hD000, 32'hE000, 16'd2);
    wait_done(50, ok);
    idle(2);
    nvec++;
    if (!ok || wlog.size() != 2 || done_cnt != 1 || done_cyc - t0 != 6) begin
      nerr++;
      $display("FAIL midrst_rerun: got ok=%0d writes=%0d done=%0d @%0d expected 1 2 1 @6",
               ok, wlog.size(), done_cnt, done_cyc - t0);
    end
    for (int i = 0; i < wlog.size() && i < 2; i++) begin
      nvec++;
      if ({wlog[i].a, wlog[i].d} !== {32'hE000 + 32'(4 * i), 32'hD000 + 32'(4 * i)}) begin
        nerr++;
        $display("FAIL midrst_write[%0d]: got %h/%h expected %h/%h", i, wlog[i].a, wlog[i].d,
                 32'hE000 + 32'(4 * i), 32'hD000 + 32'(4 * i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_len();
    test_basic_copy();
    test_backpressure();
    test_random_latency();
    test_addr_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
